// File: rtl/fp_pkg.sv
// Shared floating-point definitions for the multiplier arbiter slice.
//   fp32_t        : raw IEEE-754 single-precision bit pattern
//   FP_* constants: encodings produced or recognised by fp_mult
//   tag_t         : in-flight operation tag {valid, requester index}
package fp_pkg;

    typedef logic [31:0] fp32_t;

    localparam fp32_t FP_ZERO       = 32'h0000_0000;
    localparam fp32_t FP_INF        = 32'h7f80_0000;
    localparam fp32_t FP_INF_X_ZERO = 32'h7f80_0001;
    localparam fp32_t FP_QNAN       = 32'h7fc0_0000;

    // Wide enough for the largest supported requester count (8).
    localparam int unsigned TAG_IDX_W = 3;

    typedef struct packed {
        logic                 valid;
        logic [TAG_IDX_W-1:0] idx;
    } tag_t;

endpackage

// File: rtl/fp_mult_arbiter_if.sv
// Requester-side bundle of the multiplier arbiter.
//   req_valid/req_ready/req_dataA/req_dataB : operand handshake, 32 bits per requester
//   rsp_valid/rsp_ready/rsp_result          : held result handshake, 32 bits per requester
//   busy                                    : requester has an operation in flight or pending
// master = compute clients, slave = arbiter.
interface fp_mult_arbiter_if #(
    parameter int unsigned NUM_REQ = 4
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ*32-1:0] req_dataA;
    logic [NUM_REQ*32-1:0] req_dataB;
    logic [NUM_REQ-1:0]    rsp_valid;
    logic [NUM_REQ-1:0]    rsp_ready;
    logic [NUM_REQ*32-1:0] rsp_result;
    logic [NUM_REQ-1:0]    busy;

    modport master (
        output req_valid, req_dataA, req_dataB, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, busy
    );

    modport slave (
        input  req_valid, req_dataA, req_dataB, rsp_ready,
        output req_ready, rsp_valid, rsp_result, busy
    );
endinterface

// File: rtl/fp_mult.sv
// Single-precision multiplier, LATENCY registered stages (result valid
// LATENCY clocks after operands are presented).
//   clock        : pipeline clock
//   dataA, dataB : operands
//   result       : product
// Behaviour: subnormals flush to zero, round-to-nearest-even, any NaN
// operand gives FP_QNAN, inf*0 gives FP_INF_X_ZERO, overflow saturates
// to signed infinity, underflow gives signed zero.
module fp_mult
    import fp_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic  clock,
    input  fp32_t dataA,
    input  fp32_t dataB,
    output fp32_t result
);
    logic        w_sign;
    logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic [47:0] w_prod;
    logic [9:0]  w_exp;
    logic [23:0] w_mant;
    logic        w_guard, w_sticky;
    logic        w_ovf, w_unf;
    fp32_t       w_res;
    fp32_t       r_pipe [LATENCY];

    always_comb begin
        w_sign   = dataA[31] ^ dataB[31];
        w_a_nan  = (dataA[30:23] == 8'hff) && (dataA[22:0] != '0);
        w_b_nan  = (dataB[30:23] == 8'hff) && (dataB[22:0] != '0);
        w_a_inf  = (dataA[30:23] == 8'hff) && (dataA[22:0] == '0);
        w_b_inf  = (dataB[30:23] == 8'hff) && (dataB[22:0] == '0);
        w_a_zero = (dataA[30:23] == 8'h00);
        w_b_zero = (dataB[30:23] == 8'h00);

        w_prod = {24'd0, 1'b1, dataA[22:0]} * {24'd0, 1'b1, dataB[22:0]};
        w_exp  = {2'b00, dataA[30:23]} + {2'b00, dataB[30:23]} - 10'd127;

        // Product of two [1,2) significands lies in [1,4): normalise by one bit.
        if (w_prod[47]) begin
            w_mant   = {1'b0, w_prod[46:24]};
            w_guard  = w_prod[23];
            w_sticky = |w_prod[22:0];
            w_exp    = w_exp + 10'd1;
        end else begin
            w_mant   = {1'b0, w_prod[45:23]};
            w_guard  = w_prod[22];
            w_sticky = |w_prod[21:0];
        end

        if (w_guard && (w_sticky || w_mant[0])) begin
            w_mant = w_mant + 24'd1;
            // Fraction wrapped to zero: bump the exponent instead.
            if (w_mant[23]) begin
                w_exp = w_exp + 10'd1;
            end
        end

        // w_exp is two's complement; bit 9 set means below the normal range.
        w_unf = w_exp[9] || (w_exp == 10'd0);
        w_ovf = !w_exp[9] && (w_exp[8] || (w_exp[7:0] == 8'hff));

        if (w_a_nan || w_b_nan) begin
            w_res = FP_QNAN;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_res = FP_INF_X_ZERO;
        end else if (w_a_inf || w_b_inf || w_ovf) begin
            w_res = {w_sign, FP_INF[30:0]};
        end else if (w_a_zero || w_b_zero || w_unf) begin
            w_res = {w_sign, 31'd0};
        end else begin
            w_res = {w_sign, w_exp[7:0], w_mant[22:0]};
        end
    end

    always_ff @(posedge clock) begin
        r_pipe[0] <= w_res;
        for (int unsigned i = 1; i < LATENCY; i++) begin
            r_pipe[i] <= r_pipe[i-1];
        end
    end

    assign result = r_pipe[LATENCY-1];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter.
//   elig       : per-requester eligibility
//   last_grant : index granted most recently; search starts one above it
//   grant      : one-hot grant (all zero when nothing is eligible)
//   grant_idx  : encoded grant index (0 when nothing is eligible)
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     elig,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);
    logic             w_found;
    logic [IDX_W-1:0] w_cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        w_found   = 1'b0;
        w_cand    = '0;
        // Offset N wraps back to last_grant itself, so it is considered last.
        for (int unsigned off = 1; off <= N; off++) begin
            w_cand = IDX_W'((32'(last_grant) + off) % N);
            if (!w_found && elig[w_cand]) begin
                w_found       = 1'b1;
                grant[w_cand] = 1'b1;
                grant_idx     = w_cand;
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one fp_mult among NUM_REQ requesters with round-robin arbitration.
//   clock  : rising-edge clock
//   resetn : synchronous active-low reset
//   bus    : requester bundle (slave side): operand handshake in, held
//            per-requester results out, busy flags out
// Each granted operation is tagged with its requester index; the tag
// travels alongside fp_mult and steers the result into that requester's
// response register. A requester is ineligible while busy, so it never
// has more than one operation outstanding.
module fp_mult_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned MULT_LATENCY = 1,
    parameter int unsigned IDX_W        = $clog2(NUM_REQ)
) (
    input  logic             clock,
    input  logic             resetn,
    fp_mult_arbiter_if.slave bus
);
    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_grant;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_fire;
    fp32_t              w_opa [NUM_REQ];
    fp32_t              w_opb [NUM_REQ];
    fp32_t              w_mult_a;
    fp32_t              w_mult_b;
    fp32_t              w_mult_result;
    tag_t               w_tag_in;
    tag_t               w_tag_out;

    logic [IDX_W-1:0]   r_last_grant;
    logic [NUM_REQ-1:0] r_busy;
    logic [NUM_REQ-1:0] r_rsp_valid;
    fp32_t              r_rsp_result [NUM_REQ];
    tag_t               r_tag [MULT_LATENCY];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign w_opa[k]                  = bus.req_dataA[32*k +: 32];
        assign w_opb[k]                  = bus.req_dataB[32*k +: 32];
        assign bus.rsp_result[32*k +: 32] = r_rsp_result[k];
    end

    // Gated by resetn so req_ready is low throughout reset, even before
    // the first edge has cleared busy.
    assign w_elig = (bus.req_valid & ~r_busy) & {NUM_REQ{resetn}};

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .elig       (w_elig),
        .last_grant (r_last_grant),
        .grant      (w_grant),
        .grant_idx  (w_grant_idx)
    );

    assign w_fire        = |w_grant;
    assign bus.req_ready = w_grant;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.busy      = r_busy;

    always_comb begin
        w_mult_a       = FP_ZERO;
        w_mult_b       = FP_ZERO;
        w_tag_in.valid = w_fire;
        w_tag_in.idx   = TAG_IDX_W'(w_grant_idx);
        if (w_fire) begin
            w_mult_a = w_opa[w_grant_idx];
            w_mult_b = w_opb[w_grant_idx];
        end
    end

    fp_mult #(
        .LATENCY (MULT_LATENCY)
    ) u_mult (
        .clock  (clock),
        .dataA  (w_mult_a),
        .dataB  (w_mult_b),
        .result (w_mult_result)
    );

    assign w_tag_out = r_tag[MULT_LATENCY-1];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_busy       <= '0;
            r_rsp_valid  <= '0;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                r_rsp_result[k] <= FP_ZERO;
            end
            for (int unsigned i = 0; i < MULT_LATENCY; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (w_fire) begin
                r_last_grant <= w_grant_idx;
            end

            r_tag[0] <= w_tag_in;
            for (int unsigned i = 1; i < MULT_LATENCY; i++) begin
                r_tag[i] <= r_tag[i-1];
            end

            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                // A result for k cannot arrive while rsp_valid[k] is set
                // (busy blocks re-grant), so capture and handshake never collide.
                if (w_tag_out.valid && (w_tag_out.idx == TAG_IDX_W'(k))) begin
                    r_rsp_result[k] <= w_mult_result;
                    r_rsp_valid[k]  <= 1'b1;
                end else if (r_rsp_valid[k] && bus.rsp_ready[k]) begin
                    r_rsp_valid[k] <= 1'b0;
                    r_busy[k]      <= 1'b0;
                end
                if (w_grant[k]) begin
                    r_busy[k] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter that shares one `fp_mult` single-precision multiplier between `NUM_REQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block issues at most one multiply per cycle and tags each in-flight operation with its requester index. When the tagged result leaves the multiplier, the block returns it to that requester through a held response register. It sits between the compute clients and the one multiplier instance, so clients never drive `fp_mult` directly.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `MULT_LATENCY`, default 1: `fp_mult` latency in clocks from operand presentation to valid `result`. `fp_mult` has one registered stage.
- `IDX_W`, default `$clog2(NUM_REQ)`: requester index width (derived).

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: synchronous, active-low reset, sampled on the rising edge of `clock`.
- `req_valid` in NUM_REQ: requester i has an operand pair pending.
- `req_ready` out NUM_REQ: one-hot or zero; requester i is granted this cycle.
- `req_dataA` in NUM_REQ*32: operand A, requester i in bits [32i+31:32i].
- `req_dataB` in NUM_REQ*32: operand B, same packing as `req_dataA`.
- `rsp_valid` out NUM_REQ: result held for requester i.
- `rsp_ready` in NUM_REQ: requester i accepts its result.
- `rsp_result` out NUM_REQ*32: per-requester result, same packing as the operands.
- `busy` out NUM_REQ: requester i has an operation in flight or a response pending.

## Operation
- Eligibility: `elig[i] = req_valid[i] & ~busy[i]`. Each requester has at most one outstanding operation.
- Arbitration: round-robin over `elig`. Search starts at `last_grant+1` and wraps modulo `NUM_REQ`.
- `req_ready` is combinational from `elig` and `last_grant`. It is all-zero when no requester is eligible.
- On a grant to g (`req_valid[g] & req_ready[g]`):
  - The operands of g drive `fp_mult` `dataA`/`dataB` combinationally in the same cycle.
  - `last_grant <= g` and `busy[g] <= 1`.
  - Tag {valid=1, idx=g} enters a `MULT_LATENCY`-deep tag shift register.
- With no grant, `fp_mult` operands are driven to zero and a tag with valid=0 is shifted in.
- On a tag emerging with valid=1 and idx=k:
  - `rsp_result[k] <= fp_mult.result` and `rsp_valid[k] <= 1`.
  - The result is passed through unmodified, so `fp_mult` special encodings are preserved (inf*0 gives 0x7f800001).
- Response handshake: when `rsp_valid[k] & rsp_ready[k]`, then `rsp_valid[k] <= 0` and `busy[k] <= 0`.
  - `rsp_result[k]` holds its value until overwritten by the next result for k.
- No response can arrive for k while `rsp_valid[k]` is set, because `busy` blocks re-grant. An overwrite is therefore impossible by construction. A bench assertion checks this.
- Simultaneous events:
  - A response handshake for k and `req_valid[k]` in the same cycle: k is not eligible that cycle, because `busy` clears at the edge. The earliest re-grant is the following cycle.
  - A grant to g and a tag emerging for a different k in the same cycle: both proceed independently.
- Reset, including mid-operation:
  - `last_grant <= NUM_REQ-1`, so requester 0 has first priority.
  - All tag valids are cleared, which discards in-flight operations.
  - `busy`, `rsp_valid` and `rsp_result` are cleared to 0; `req_ready` is 0 while `resetn` is low.

## Timing
- Grant in cycle T. `fp_mult` result is valid in T+`MULT_LATENCY` and captured at the end of that cycle. `rsp_valid` is high from T+`MULT_LATENCY`+1, which is T+2 for the default.
- Throughput: one grant per cycle across all requesters.
- Per-requester issue rate: one operation per (`MULT_LATENCY`+2) cycles minimum, when `rsp_ready` is held high.
- Fairness: with all requesters continuously eligible, each is granted once in any window of `NUM_REQ` consecutive grants.
- Output reset values: `req_ready`, `rsp_valid`, `busy` and `rsp_result` are all 0.

## Structure
- Shared package `fp_pkg`:
  - Constants `FP_ZERO`=32'h00000000, `FP_INF`=32'h7f800000, `FP_INF_X_ZERO`=32'h7f800001.
  - Typedef `fp32_t` (32-bit).
  - Tag struct {valid, idx}.
- Sub-module `rr_arbiter`: parameter N; inputs `elig` and `last_grant`; outputs one-hot `grant` and encoded `grant_idx`. It is purely combinational.
- Top level:
  - Instantiates `rr_arbiter`, one `fp_mult`, the tag shift register and the per-requester response registers.
  - Operands reach `fp_mult` through an operand mux indexed by `grant_idx`.

## Test plan
- Single request: req0 A=0x41400000, B=0x41400000 -> grant at T; `rsp_valid[0]` at T+2; `rsp_result[0]`=0x43100000 (12*12=144).
- Special values on three requesters:
  - req1 0x00000000*0x41400000 -> 0x00000000.
  - req2 0x7f800000*0x00000000 -> 0x7f800001.
  - req3 0x7f800001*0x41400000 -> NaN from `fp_mult`, passed through unmodified.
- All 4 requesting continuously with `rsp_ready`=1 -> grant order 0,1,2,3,0,... and one grant per cycle; each result lands at the correct index.
- Backpressure: `rsp_ready[2]`=0 for 10 cycles -> `rsp_valid[2]` and `rsp_result[2]` hold; requester 2 gets no grant; the others proceed. After `rsp_ready[2]`=1, requester 2 is re-granted no earlier than the next cycle.
- Reset asserted the cycle after a grant -> no `rsp_valid` appears; all outputs are 0; after release, the first grant goes to requester 0.
